// File: rtl/seq_detect_pkg.sv
// Shared definitions for the programmable sequence detector.
//   PAT_W / CFG_LEN_W : storage widths of the configuration shadow fields.
//                       PAT_W bounds the supported MAX_LEN (MAX_LEN <= PAT_W).
//   DEF_*             : power-up configuration; this reproduces the legacy
//                       fixed "1101" non-overlapping detector.
//   cfg_t             : shadow configuration record (pattern, len, overlap).
//   len_mask()        : ones in the low 'len' bit positions.
package seq_detect_pkg;

  localparam int PAT_W     = 32;
  localparam int CFG_LEN_W = 8;

  localparam logic [3:0] DEF_PATTERN = 4'b1101;
  localparam int         DEF_LEN     = 4;
  localparam logic       DEF_OVERLAP = 1'b0;

  typedef struct packed {
    logic [PAT_W-1:0]     pattern;
    logic [CFG_LEN_W-1:0] len;
    logic                 overlap;
  } cfg_t;

  function automatic logic [PAT_W-1:0] len_mask(input logic [CFG_LEN_W-1:0] len);
    logic [PAT_W-1:0] m;
    for (int i = 0; i < PAT_W; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating event counter with synchronous clear and sticky saturation flag.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear of count and sat (wins over inc)
//   inc        : count one event
//   count      : event count, holds at all-ones
//   sat        : set on the edge where count reaches all-ones, cleared by clr
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_inc;

  assign count_inc = count + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && (count != '1)) begin
      count <= count_inc;
      if (count_inc == '1) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-sequence detector (Moore output).
//   clk, reset  : clock, asynchronous active-high reset
//   cfg_load    : latch cfg_pattern/cfg_len/cfg_overlap and restart detection
//   cfg_pattern : right-aligned pattern, bit [len-1] is received first
//   cfg_len     : pattern length (0 disables, > MAX_LEN clamps to MAX_LEN)
//   cfg_overlap : 1 = overlapping matches allowed
//   in_valid/in : serial bit stream with qualifier
//   clr_count   : synchronous clear of match_count / count_sat
//   out         : registered one-cycle detect pulse
//   match_count : saturating number of detections
//   count_sat   : sticky, match_count has reached all-ones
// MAX_LEN must not exceed seq_detect_pkg::PAT_W.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in,
  input  logic               clr_count,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam int DEF_LEN_CLAMP = (DEF_LEN > MAX_LEN) ? MAX_LEN : DEF_LEN;
  localparam cfg_t CFG_DEFAULT = '{pattern: PAT_W'(DEF_PATTERN),
                                   len:     CFG_LEN_W'(DEF_LEN_CLAMP),
                                   overlap: DEF_OVERLAP};

  // Only MAX_LEN-1 history bits are stored: the newest bit of any
  // comparison comes straight from 'in', and the oldest stored bit
  // would be shifted out before it could ever be compared again.
  cfg_t               cfg_p0;
  logic [MAX_LEN-2:0] hist_p0;
  logic [LEN_W-1:0]   fill_p0;
  logic               det_p1;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W:0]     fill_inc;
  logic [LEN_W-1:0]   fill_nxt;
  logic [PAT_W-1:0]   mask;
  logic               full;
  logic               match;
  logic               accept;
  logic [LEN_W-1:0]   len_clamped;

  assign accept      = in_valid & ~cfg_load;
  assign len_clamped = (int'(cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;

  always_comb begin
    hist_nxt = {hist_p0, in};
    fill_inc = (LEN_W + 1)'(fill_p0) + (LEN_W + 1)'(1);
    mask     = len_mask(cfg_p0.len);
    full     = (int'(fill_inc) >= int'(cfg_p0.len));
    // fill gates out stale history left over from before a restart.
    match    = (cfg_p0.len != '0) && full &&
               ((PAT_W'(hist_nxt) & mask) == (cfg_p0.pattern & mask));
    if (match && !cfg_p0.overlap) begin
      fill_nxt = '0;
    end else if (full) begin
      fill_nxt = LEN_W'(cfg_p0.len);
    end else begin
      fill_nxt = LEN_W'(fill_inc);
    end
  end

  // Stage p0 -> p1: shadow config, history, fill and registered detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_p0  <= CFG_DEFAULT;
      hist_p0 <= '0;
      fill_p0 <= '0;
      det_p1  <= 1'b0;
    end else if (cfg_load) begin
      cfg_p0.pattern <= PAT_W'(cfg_pattern);
      cfg_p0.len     <= CFG_LEN_W'(len_clamped);
      cfg_p0.overlap <= cfg_overlap;
      hist_p0        <= '0;
      fill_p0        <= '0;
      det_p1         <= 1'b0;
    end else if (in_valid) begin
      hist_p0 <= hist_nxt[MAX_LEN-2:0];
      fill_p0 <= fill_nxt;
      det_p1  <= match;
    end else begin
      det_p1  <= 1'b0;
    end
  end

  assign out = det_p1;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_count),
    .inc   (accept & match),
    .count (match_count),
    .sat   (count_sat)
  );

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable serial bit-sequence detector; the parametrised successor to the fixed 1101 Moore detector. The target pattern (1..MAX_LEN bits), the pattern length and overlap/non-overlap mode are runtime-configurable. A saturating match counter is included. It sits on a single-bit serial input stream, with a valid qualifier, and drives a registered (Moore) one-cycle detect pulse.

## Interface
Parameters:
- MAX_LEN, 8: longest supported pattern, in bits (≥2).
- LEN_W, $clog2(MAX_LEN+1): width of cfg_len.
- CNT_W, 8: match counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- cfg_load  input  1  latch cfg_* into shadow registers and restart detection.
- cfg_pattern  input  MAX_LEN  pattern, right-aligned. Bit [len-1] is the first bit received.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping detection; 0 = non-overlapping.
- in_valid  input  1  in is sampled only when high.
- in  input  1  serial data bit.
- clr_count  input  1  synchronous clear of match_count and count_sat.
- out  output  1  detect pulse (registered).
- match_count  output  CNT_W  number of detections, saturating.
- count_sat  output  1  sticky flag: match_count has reached all-ones.

## Operation
- Shadow config reset values: pattern = 4'b1101 (zero-extended), len = 4, overlap = 0. This gives backward compatibility with the fixed 1101 non-overlapping detector.
- Internal state:
  - hist: MAX_LEN-bit shift register; the new bit enters at bit 0.
  - fill: LEN_W-bit count of valid bits held since the last restart, saturating at len.
  - out register.
- Accept edge = rising edge with in_valid=1 and cfg_load=0. On an accept edge:
  - hist <= {hist[MAX_LEN-2:0], in}.
  - match = (fill+1 ≥ len) and (new hist[len-1:0] == pattern[len-1:0]).
  - out <= match.
  - If match and overlap=0: fill <= 0. Otherwise fill <= min(fill+1, len).
- Non-accept edge: out <= 0. hist and fill hold.
- cfg_load=1 edge:
  - Shadows <= cfg_*. hist, fill and out <= 0.
  - Concurrent in is discarded.
  - match_count is unchanged.
- Length rules:
  - len = 0 disables detection; out stays 0.
  - cfg_len > MAX_LEN is clamped to MAX_LEN at load.
- match_count:
  - Increments on the same edge that sets out=1.
  - Saturates at 2^CNT_W−1; count_sat is set at that same edge.
  - clr_count=1: count <= 0, count_sat <= 0. If a match occurs on the same edge, clr wins and count is 0.
- Reset values: out=0, match_count=0, count_sat=0, hist=0, fill=0, shadows at the defaults above.
- Reset mid-stream: all partial progress is lost; detection restarts from an empty history.

## Timing
- Latency: the final pattern bit accepted at edge k gives out=1 during the cycle after edge k, for exactly one cycle. match_count updates at the same edge.
- out is a pure register; there is no combinational path from in or in_valid.
- Back-to-back detections:
  - Overlap mode: out can be high on consecutive cycles (e.g. pattern 11, len 2).
  - Non-overlap mode: successive pulses are at least len accepted bits apart.
- in_valid gaps do not break a partial match. Only accepted bits count.
- cfg_load takes effect at its edge. The first bit accepted on the following edge is bit 1 of the new sequence.

## Structure
- Package seq_detect_pkg holds:
  - the default pattern/length/overlap constants (DEF_PATTERN=4'b1101, DEF_LEN=4, DEF_OVERLAP=0);
  - a config struct (pattern, len, overlap) used for the shadow registers.
- One sub-module, sat_counter: a CNT_W-wide saturating incrementer with sync clear and sticky saturation flag. It is instantiated for match_count/count_sat.
- hist/fill/compare logic stays in seq_detect_prog.

## Test plan
- After reset, default config, bits 1101 1101 (in_valid=1 throughout): out pulses in the cycles after bits 4 and 8; match_count=2.
- Default config, 1101101: non-overlap gives one pulse (after bit 4). cfg_load with overlap=1, same stream: pulses after bits 4 and 7.
- Pattern 10110, len 5, in_valid low for 3 cycles between bits 2 and 3: single pulse after bit 5; out=0 during the gap.
- Default config, send 110, then cfg_load (same config) concurrent with in=1, then 1101: only one pulse, after the final 1101. The load-edge bit is ignored.
- len=0 loaded, 16 random bits: out never 1. len=9 loaded with MAX_LEN=8: behaves as len 8.
- CNT_W=2, five detections: match_count 1,2,3,3,3 and count_sat set at the third. clr_count concurrent with a match: count=0. Reset asserted mid-pattern: out=0 immediately, and the next full pattern is still detected.
